// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and sizing helpers for the cache fill arbiter and its address generator.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} fill_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

  localparam int BLK_WORDS_DEFAULT = 8;
  localparam int WORD_IDX_W        = $clog2(BLK_WORDS_DEFAULT);
  localparam int BLK_OFFSET_W      = WORD_IDX_W + 1;

  // Word-index width for an arbitrary block size (BLK_WORDS is a power of two, >= 2).
  function automatic int word_idx_w(input int blk_words);
    return $clog2(blk_words);
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Main-memory port bundle: the arbiter is the master, the memory controller the slave.
interface cache_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_data_valid, mem_rdata
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_data_valid, mem_rdata
  );
endinterface

// File: rtl/cache_fill_arbiter_fill_addr_gen.sv
// Block-fill address generator: latches the block base, counts issued reads and returned words.
module fill_addr_gen
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BLK_WORDS = BLK_WORDS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic                             issue,
  input  logic                             ret,
  output logic [ADDR_W-1:0]                rd_addr,
  output logic [word_idx_w(BLK_WORDS)-1:0] word_idx,
  output logic                             issue_done,
  output logic                             last_ret
);
  localparam int IDX_W = word_idx_w(BLK_WORDS);
  localparam int OFF_W = IDX_W + 1;

  logic [ADDR_W-1:0] base;
  logic [IDX_W:0]    issue_cnt;
  logic [IDX_W-1:0]  ret_cnt;

  // Base is only observed while a fill is issuing, so it needs no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      base <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (start) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + (IDX_W+1)'(1);
      if (ret)   ret_cnt   <= ret_cnt + IDX_W'(1);
    end
  end

  assign rd_addr    = base | ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
  assign word_idx   = ret_cnt;
  assign issue_done = issue_cnt[IDX_W];
  assign last_ret   = &ret_cnt;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shared memory-port arbiter and block-fill sequencer for the I- and D-caches.
// Define CACHE_FILL_ARBITER_PERF_CNT_EN to add the ifill_cnt/dfill_cnt completion counters.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = BLK_WORDS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             icache_miss,
  input  logic [ADDR_W-1:0]                icache_miss_addr,
  input  logic                             dcache_miss,
  input  logic [ADDR_W-1:0]                dcache_miss_addr,
  input  logic                             dcache_wr_req,
  input  logic [ADDR_W-1:0]                dcache_wr_addr,
  input  logic [DATA_W-1:0]                dcache_wr_data,
  cache_fill_arbiter_if.master             mem,
  output logic                             fill_we,
  output logic                             fill_tag_we,
  output logic [word_idx_w(BLK_WORDS)-1:0] fill_word_idx,
  output logic [DATA_W-1:0]                fill_data,
  output logic                             fill_to_icache,
  output logic                             istall,
  output logic                             dstall,
  output logic                             busy
`ifdef CACHE_FILL_ARBITER_PERF_CNT_EN
  ,
  output logic [15:0]                      ifill_cnt,
  output logic [15:0]                      dfill_cnt
`endif
);
  localparam int IDX_W = word_idx_w(BLK_WORDS);

  fill_state_t      state;
  grant_t           grant;
  logic             start;
  logic             rd_en;
  logic             issue_done;
  logic             last_ret;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  ret_idx;

  // A store pending in IDLE always wins; loads beat fetches.
  assign start      = (state == IDLE) && !dcache_wr_req && (dcache_miss || icache_miss);
  assign start_addr = dcache_miss ? dcache_miss_addr : icache_miss_addr;

  fill_addr_gen #(
    .ADDR_W   (ADDR_W),
    .BLK_WORDS(BLK_WORDS)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .req_addr  (start_addr),
    .issue     (rd_en),
    .ret       (fill_we),
    .rd_addr   (rd_addr),
    .word_idx  (ret_idx),
    .issue_done(issue_done),
    .last_ret  (last_ret)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= GNT_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (dcache_wr_req) begin
            state <= WRITE;
          end else if (dcache_miss) begin
            state <= FILL;
            grant <= GNT_D;
          end else if (icache_miss) begin
            state <= FILL;
            grant <= GNT_I;
          end
        end
        WRITE: state <= IDLE;
        FILL: begin
          if (fill_tag_we) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
        default: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

  assign rd_en          = (state == FILL) && !issue_done;
  assign fill_we        = (state == FILL) && mem.mem_data_valid;
  assign fill_tag_we    = fill_we && last_ret;
  assign fill_word_idx  = ret_idx;
  assign fill_data      = mem.mem_rdata;
  assign fill_to_icache = (grant == GNT_I);
  assign busy           = (state != IDLE);

  // Stalls are forced low while reset is held so every output reads 0 during reset.
  assign istall = !rst && icache_miss && !((state == DONE) && (grant == GNT_I));
  assign dstall = !rst && ((dcache_miss && !((state == DONE) && (grant == GNT_D)))
                           || dcache_wr_req || (state == WRITE));

  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state == WRITE) begin
      mem.mem_en    = 1'b1;
      mem.mem_wr    = 1'b1;
      mem.mem_addr  = dcache_wr_addr;
      mem.mem_wdata = dcache_wr_data;
    end else if (rd_en) begin
      mem.mem_en   = 1'b1;
      mem.mem_addr = rd_addr;
    end
  end

`ifdef CACHE_FILL_ARBITER_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifill_cnt <= '0;
      dfill_cnt <= '0;
    end else if (fill_tag_we) begin
      if (grant == GNT_I) ifill_cnt <= sat_inc(ifill_cnt);
      else                dfill_cnt <= sat_inc(dfill_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: 4-cycle pipelined memory model with read/write/fill scoreboards.
// Define CACHE_FILL_ARBITER_PERF_CNT_EN to also exercise the fill counters.
module tb_cache_fill_arbiter;
  localparam int ADDR_W = 16, DATA_W = 16, BLK_WORDS = 8, LAT = 4;

  typedef struct { logic [2:0] idx; logic [15:0] data; logic icache; logic tag; } fill_exp_t;
  typedef struct { int due; logic [15:0] data; } ret_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        icache_miss, dcache_miss, dcache_wr_req;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
  logic        fill_we, fill_tag_we, fill_to_icache, istall, dstall, busy;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data;
`ifdef CACHE_FILL_ARBITER_PERF_CNT_EN
  logic [15:0] ifill_cnt, dfill_cnt;
`endif

  cache_fill_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

  cache_fill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK_WORDS)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem(mem),
    .fill_we(fill_we), .fill_tag_we(fill_tag_we), .fill_word_idx(fill_word_idx),
    .fill_data(fill_data), .fill_to_icache(fill_to_icache),
    .istall(istall), .dstall(dstall), .busy(busy)
`ifdef CACHE_FILL_ARBITER_PERF_CNT_EN
    , .ifill_cnt(ifill_cnt), .dfill_cnt(dfill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int fill_seen = 0, tags = 0, wr_seen = 0, stale = 0;
  int n, cnt, t0, w0, f0, s0;
  logic last_en = 1'b0, last_wr = 1'b0;
  logic tag_i = 1'b0, tag_d = 1'b0, done_i = 1'b0, done_d = 1'b0, drop_wr = 1'b0;

  fill_exp_t   fill_q[$];
  logic [15:0] rd_q[$];
  logic [31:0] wr_q[$];
  ret_t        ret_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Memory: each read seen in cycle c returns its word during cycle c+LAT.
  initial begin
    ret_t r;
    mem.mem_data_valid = 1'b0;
    mem.mem_rdata      = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        r = ret_q.pop_front();
        mem.mem_data_valid = 1'b1;
        mem.mem_rdata      = r.data;
      end else begin
        mem.mem_data_valid = 1'b0;
        mem.mem_rdata      = 16'($urandom);
      end
    end
  end

  task automatic monitor();
    ret_t        r;
    fill_exp_t   e;
    logic [15:0] a;
    logic [31:0] w;
    last_en = mem.mem_en;
    last_wr = mem.mem_wr;
    if (mem.mem_en && !mem.mem_wr) begin
      r.due  = cyc + LAT;
      r.data = mdata(mem.mem_addr);
      ret_q.push_back(r);
      if (rd_q.size() == 0) chk("rd_extra", rd_q.size(), 1);
      else begin
        a = rd_q.pop_front();
        chk("rd_addr", mem.mem_addr, a);
      end
    end
    if (mem.mem_en && mem.mem_wr) begin
      wr_seen++;
      drop_wr = 1'b1;
      if (wr_q.size() == 0) chk("wr_extra", wr_q.size(), 1);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr_data", {mem.mem_addr, mem.mem_wdata}, w);
      end
    end
    if (fill_we) begin
      fill_seen++;
      if (fill_q.size() == 0) chk("fill_extra", fill_q.size(), 1);
      else begin
        e = fill_q.pop_front();
        chk("fill_idx", fill_word_idx, e.idx);
        chk("fill_data", fill_data, e.data);
        chk("fill_tgt", fill_to_icache, e.icache);
        chk("fill_tag", fill_tag_we, e.tag);
      end
      if (fill_tag_we) begin
        tags++;
        if (fill_to_icache) tag_i = 1'b1;
        else tag_d = 1'b1;
      end
    end
    if (mem.mem_data_valid && !busy) stale++;
  endtask

  // One cycle: sample at the falling edge, then let the caches react 1ns later.
  task automatic tick();
    @(negedge clk);
    if (!rst) monitor();
    #1;
    if (done_i) begin icache_miss = 1'b0; done_i = 1'b0; end
    if (done_d) begin dcache_miss = 1'b0; done_d = 1'b0; end
    if (tag_i) begin done_i = 1'b1; tag_i = 1'b0; end
    if (tag_d) begin done_d = 1'b1; tag_d = 1'b0; end
    if (drop_wr) begin dcache_wr_req = 1'b0; drop_wr = 1'b0; end
  endtask

  task automatic expect_fill(input logic [15:0] base, input logic icache);
    fill_exp_t e;
    for (int i = 0; i < BLK_WORDS; i++) begin
      rd_q.push_back(base + 16'(2 * i));
      e.idx    = 3'(i);
      e.data   = mdata(base + 16'(2 * i));
      e.icache = icache;
      e.tag    = (i == BLK_WORDS - 1);
      fill_q.push_back(e);
    end
  endtask

  task automatic wait_quiet(input string tag);
    int k;
    k = 0;
    while ((busy || icache_miss || dcache_miss || dcache_wr_req ||
            rd_q.size() != 0 || fill_q.size() != 0 || wr_q.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, rd_q.size() + fill_q.size() + wr_q.size() + int'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_en"}, mem.mem_en, 0);
    chk({tag, "_mem_wr"}, mem.mem_wr, 0);
    chk({tag, "_mem_addr"}, mem.mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem.mem_wdata, 0);
    chk({tag, "_fill_we"}, fill_we, 0);
    chk({tag, "_fill_tag_we"}, fill_tag_we, 0);
    chk({tag, "_fill_idx"}, fill_word_idx, 0);
    chk({tag, "_fill_to_i"}, fill_to_icache, 0);
    chk({tag, "_istall"}, istall, 0);
    chk({tag, "_dstall"}, dstall, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_fill(input logic [15:0] addr, input logic [15:0] base, input logic icache);
    if (icache) begin icache_miss_addr = addr; icache_miss = 1'b1; end
    else begin dcache_miss_addr = addr; dcache_miss = 1'b1; end
    expect_fill(base, icache);
    wait_quiet("fill");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr_req = 1'b0;
    icache_miss_addr = '0; dcache_miss_addr = '0; dcache_wr_addr = '0; dcache_wr_data = '0;
    repeat (2) tick();
    check_zero("rst0");
    rst = 1'b0;
    tick();

    // I-miss alone: 13 stalled cycles counting the arbitration cycle.
    icache_miss_addr = 16'h1236;
    icache_miss = 1'b1;
    expect_fill(16'h1230, 1'b1);
    n = 0;
    do begin tick(); n++; end while (istall && n < 40);
    chk("i_penalty", n, 13);
    wait_quiet("imiss");

    // Simultaneous misses: D first, I-cache stalled until its own DONE.
    dcache_miss_addr = 16'h4010; icache_miss_addr = 16'h0020;
    dcache_miss = 1'b1; icache_miss = 1'b1;
    expect_fill(16'h4010, 1'b0);
    expect_fill(16'h0020, 1'b1);
    t0 = tags; n = 0; cnt = 0;
    while (tags < t0 + 2 && n < 100) begin
      tick(); n++;
      if (!istall) cnt++;
    end
    chk("sim_fills", tags - t0, 2);
    chk("sim_istall_low", cnt, 0);
    wait_quiet("sim");

    // Store arrives mid I-fill; the I address also changes and must be ignored.
    icache_miss_addr = 16'h5552;
    icache_miss = 1'b1;
    expect_fill(16'h5550, 1'b1);
    repeat (4) tick();
    icache_miss_addr = 16'hFFFF;
    dcache_wr_addr = 16'h8000; dcache_wr_data = 16'hBEEF; dcache_wr_req = 1'b1;
    wr_q.push_back({16'h8000, 16'hBEEF});
    t0 = tags; w0 = wr_seen; n = 0; cnt = 0;
    while (wr_seen == w0 && n < 60) begin
      tick(); n++;
      if (wr_seen == w0 && !dstall) cnt++;
      if (wr_seen != w0) chk("st_after_done", tags - t0, 1);
    end
    chk("st_wr_seen", wr_seen - w0, 1);
    chk("st_dstall_low", cnt, 0);
    wait_quiet("store");

    // Store and load miss together: WRITE first, then the D fill.
    dcache_wr_addr = 16'h9002; dcache_wr_data = 16'h1234; dcache_wr_req = 1'b1;
    dcache_miss_addr = 16'h600E; dcache_miss = 1'b1;
    wr_q.push_back({16'h9002, 16'h1234});
    expect_fill(16'h6000, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!last_en && n < 10);
    chk("prio_write_first", last_wr, 1);
    wait_quiet("prio");

    // Reset after three returns; stale returns must not fill.
    icache_miss_addr = 16'h2468;
    icache_miss = 1'b1;
    expect_fill(16'h2460, 1'b1);
    f0 = fill_seen; n = 0;
    while (fill_seen - f0 < 3 && n < 30) begin tick(); n++; end
    chk("rst_three_returns", fill_seen - f0, 3);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    icache_miss = 1'b0;
    rd_q.delete(); fill_q.delete();
    tag_i = 1'b0; tag_d = 1'b0; done_i = 1'b0; done_d = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    s0 = stale;
    repeat (8) tick();
    chk("stale_seen", int'(stale > s0), 1);
    do_fill(16'h3004, 16'h3000, 1'b1);

`ifdef CACHE_FILL_ARBITER_PERF_CNT_EN
    do_fill(16'h0102, 16'h0100, 1'b1);
    do_fill(16'h0A00, 16'h0A00, 1'b0);
    do_fill(16'h0204, 16'h0200, 1'b1);
    do_fill(16'h0B1E, 16'h0B10, 1'b0);
    chk("perf_ifill", ifill_cnt, 3);
    chk("perf_dfill", dfill_cnt, 2);
    force dut.ifill_cnt = 16'hFFFF;
    tick();
    release dut.ifill_cnt;
    do_fill(16'h0300, 16'h0300, 1'b1);
    chk("perf_ifill_sat", ifill_cnt, 16'hFFFF);
    chk("perf_dfill_hold", dfill_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
